chip8_key_state: RTL
====================

Name: chip8_key_state

Overview:
- Sits directly downstream of the CHIP-8 keypad scanner. Consumes its once-per-poll key report (key index plus valid flag).
- Debounces the report into a stable key state.
- Serves the CPU's two key needs:
  - Registered "is key X down" query for EX9E/EXA1.
  - Press-then-release wait handshake for FX0A.

Parameters:
- DEBOUNCE_SAMPLES, 3, number of consecutive identical scanner reports required before the stable state changes (legal range 1..15).

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- scan_key_in  input  4  key index reported by the scanner
- scan_valid_in  input  1  scanner report: exactly one key is down
- scan_strobe_in  input  1  one-cycle pulse; scan_key_in/scan_valid_in hold a new report this cycle
- stable_key_out  output  4  debounced key index; meaningful only when stable_valid_out=1
- stable_valid_out  output  1  debounced "one key held"
- key_change_out  output  1  one-cycle pulse when stable_valid_out or stable_key_out changes
- query_key_in  input  4  key index the CPU is testing
- query_pressed_out  output  1  registered: stable_valid_out && stable_key_out==query_key_in
- wait_req_in  input  1  one-cycle pulse; CPU starts FX0A wait
- wait_cancel_in  input  1  abort an outstanding wait
- wait_busy_out  output  1  wait in progress
- wait_done_out  output  1  one-cycle pulse; wait_key_out valid this cycle
- wait_key_out  output  4  key that completed the wait

Behaviour:
- Async reset (rst_n_in=0): all outputs 0; debounce candidate = "no key"; count = 0; FSM = IDLE.
- Sample: a report is (scan_valid_in, scan_key_in).
  - scan_valid_in=0 means "no key", whatever scan_key_in is; this includes multi-key reports.
  - Two "no key" samples match each other.
  - Two valid samples match only if their keys are equal.
- Debounce, evaluated only on cycles with scan_strobe_in=1:
  - If the sample matches the candidate: count <= min(count+1, DEBOUNCE_SAMPLES).
  - Otherwise: candidate <= sample; count <= 1.
  - When the new count equals DEBOUNCE_SAMPLES, stable <= candidate on that same edge. With DEBOUNCE_SAMPLES=1, every strobe updates stable directly.
  - On a "no key" update, stable_key_out holds its old value.
  - key_change_out pulses on the edge where stable_valid_out changes, or where stable_key_out changes while valid.
  - Count is 4 bits and saturates; it never wraps.
- Query: query_pressed_out is updated every cycle from the current stable state and query_key_in. Latency is 1 cycle.
- Wait FSM states: IDLE, ARM, PRESS, RELEASE. wait_busy_out=1 in ARM, PRESS and RELEASE.
  - IDLE: on wait_req_in, go to ARM if stable_valid_out=1, else PRESS. A key already held at request must be released before it can count.
  - ARM: when stable_valid_out=0, go to PRESS.
  - PRESS: when stable_valid_out=1, latch stable_key_out into wait_key_out and go to RELEASE.
  - RELEASE: complete when stable_valid_out=0 or stable_key_out differs from the latch. On completion pulse wait_done_out for 1 cycle, keep wait_key_out at the latched key, and go to IDLE.
  - FSM transitions use registered stable state, so completion happens 1 cycle after the stable edge.
- Boundaries:
  - wait_req_in while busy is ignored.
  - wait_cancel_in in any state forces IDLE on the next edge with no done pulse; cancel wins over a simultaneous req or completion.
  - wait_key_out holds its value until the next latch.
  - scan_strobe_in=0 freezes the debounce state.
  - Reset asserted mid-wait aborts it; wait_done_out stays 0.

Test Plan:
- DEBOUNCE_SAMPLES=3; strobes with key 5 valid ×2, then ×1 more -> stable_valid_out rises on the 3rd strobe edge, stable_key_out=5, key_change_out pulses once.
- Strobes: key 5, key 5, key 7, key 5, key 5 -> no stable change. A bounce resets the count; stable updates only on the 3rd consecutive key 5.
- Stable key 0xA held; query_key_in=0xA then 0xB -> query_pressed_out 1 then 0, each 1 cycle after the query changes.
- Idle keypad; wait_req_in; stable press of 0xC then release -> wait_busy_out=1 throughout; wait_done_out pulses once with wait_key_out=0xC, 1 cycle after stable_valid_out falls.
- Key 3 stable-held at wait_req_in -> FSM goes to ARM. Release 3, press then release 9 -> done with wait_key_out=9, never 3.
- Cancel mid-RELEASE, and rst_n_in low mid-PRESS -> no wait_done_out pulse; busy=0 next edge or immediately on reset; all outputs 0 after reset.

Source files
------------

// File: rtl/chip8_key_state.sv
// chip8_key_state: debounces CHIP-8 keypad scanner reports into a stable key state,
// answers the CPU "is key X down" query and runs the FX0A press-then-release wait.
// Ports:
//   clk_in, rst_n_in                        clock, asynchronous active-low reset
//   scan_key_in/scan_valid_in/scan_strobe_in  scanner report, qualified by strobe
//   stable_key_out/stable_valid_out         debounced key state
//   key_change_out                          pulse when the debounced state changes
//   query_key_in -> query_pressed_out       registered key-down query
//   wait_req_in/wait_cancel_in              start / abort an FX0A wait
//   wait_busy_out/wait_done_out/wait_key_out  wait status and result
module chip8_key_state #(
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [3:0] scan_key_in,
    input  logic       scan_valid_in,
    input  logic       scan_strobe_in,
    output logic [3:0] stable_key_out,
    output logic       stable_valid_out,
    output logic       key_change_out,
    input  logic [3:0] query_key_in,
    output logic       query_pressed_out,
    input  logic       wait_req_in,
    input  logic       wait_cancel_in,
    output logic       wait_busy_out,
    output logic       wait_done_out,
    output logic [3:0] wait_key_out
);
    localparam logic [3:0] LIMIT = 4'(DEBOUNCE_SAMPLES);

    typedef enum logic [1:0] {IDLE, ARM, PRESS, RELEASE} wait_state_t;

    wait_state_t state;
    logic        cand_valid;
    logic [3:0]  cand_key;
    logic [3:0]  count;
    logic        match;
    logic [3:0]  next_count;
    logic        settle;

    // "No key" samples match each other regardless of the reported index.
    always_comb begin
        match      = (cand_valid == scan_valid_in) && (!scan_valid_in || cand_key == scan_key_in);
        next_count = !match ? 4'd1 : (count >= LIMIT) ? LIMIT : count + 4'd1;
        settle     = scan_strobe_in && next_count == LIMIT;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cand_valid       <= 1'b0;
            cand_key         <= 4'd0;
            count            <= 4'd0;
            stable_valid_out <= 1'b0;
            stable_key_out   <= 4'd0;
            key_change_out   <= 1'b0;
        end else begin
            key_change_out <= 1'b0;
            if (scan_strobe_in) begin
                cand_valid <= scan_valid_in;
                cand_key   <= scan_key_in;
                count      <= next_count;
            end
            // A saturated, still-matching candidate re-settles to the same value,
            // so the change flag stays low in that case.
            if (settle) begin
                stable_valid_out <= scan_valid_in;
                if (scan_valid_in)
                    stable_key_out <= scan_key_in;
                key_change_out <= (stable_valid_out != scan_valid_in) ||
                                  (scan_valid_in && stable_key_out != scan_key_in);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            query_pressed_out <= 1'b0;
        else
            query_pressed_out <= stable_valid_out && stable_key_out == query_key_in;
    end

    assign wait_busy_out = state != IDLE;

    // A key already held at request time parks in ARM until released, so only a
    // fresh press can complete the wait.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            wait_done_out <= 1'b0;
            wait_key_out  <= 4'd0;
        end else begin
            wait_done_out <= 1'b0;
            if (wait_cancel_in) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:
                        if (wait_req_in)
                            state <= stable_valid_out ? ARM : PRESS;
                    ARM:
                        if (!stable_valid_out)
                            state <= PRESS;
                    PRESS:
                        if (stable_valid_out) begin
                            wait_key_out <= stable_key_out;
                            state        <= RELEASE;
                        end
                    RELEASE:
                        if (!stable_valid_out || stable_key_out != wait_key_out) begin
                            wait_done_out <= 1'b1;
                            state         <= IDLE;
                        end
                    default:
                        state <= IDLE;
                endcase
            end
        end
    end
endmodule
